cic3_row_readout: RTL and testbench



---
 rtl/cic3_row_readout.sv | 180 ++++++++++++++++++
 tb/tb_cic3_row_readout.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic3_row_readout.sv
// Framed MSB-first serial readout of one row of CIC3 filter words, one word per enabled channel.
// Optional even-parity bit after each word: define CIC3_READOUT_PARITY_EN.
module cic3_row_readout #(
    parameter int NUM_CH = 12,
    parameter int WIDTH  = 25,
    parameter int DIV    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic                    data_valid,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    ovr_clr,
    output logic                    sout,
    output logic                    sframe,
    output logic                    sbit_strobe,
    output logic                    busy,
    output logic                    overrun
);

`ifdef CIC3_READOUT_PARITY_EN
    localparam int WORD = WIDTH + 1;
`else
    localparam int WORD = WIDTH;
`endif
    localparam int BIT_W = (WORD > 1) ? $clog2(WORD) : 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic [BIT_W-1:0]   bit_cnt, bit_n, bit_nx, bit_sel;
    logic [CH_W-1:0]    ch_ptr, ch_n;
    logic [NUM_CH-1:0]  shadow_en;
    logic [WIDTH-1:0]   shadow_word [NUM_CH];
    logic [WIDTH-1:0]   in_word [NUM_CH];
    logic [WIDTH-1:0]   cur_word;
    logic               sout_n, sframe_n, strobe_n, busy_n, ovr_n;
    logic               capture, next_bit;
    logic               first_found, next_found;
    logic [CH_W-1:0]    first_idx, next_idx;

    // Lowest enabled channel strictly above index 'above'; MSB of the result flags a hit.
    function automatic logic [CH_W:0] lowest_ch(input logic [NUM_CH-1:0] en, input int above);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en[i] && i > above) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) in_word[k] = data_in[k*WIDTH +: WIDTH];
    end

    assign {first_found, first_idx} = lowest_ch(ch_en, -1);
    assign {next_found, next_idx}   = lowest_ch(shadow_en, int'(ch_ptr));

    assign cur_word = shadow_word[ch_ptr];
    assign bit_nx   = bit_cnt + 1'b1;
    assign bit_sel  = BIT_W'(WIDTH - 1) - bit_nx;

    always_comb begin
        next_bit = cur_word[bit_sel];
`ifdef CIC3_READOUT_PARITY_EN
        if (bit_nx == BIT_W'(WIDTH)) next_bit = ^cur_word;
`endif
    end

    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        ch_n     = ch_ptr;
        sout_n   = sout;
        sframe_n = sframe;
        strobe_n = 1'b0;
        busy_n   = busy;
        ovr_n    = overrun;
        capture  = 1'b0;

        // A strobe arriving while busy is an overrun; set beats clear.
        if (data_valid && state != IDLE) ovr_n = 1'b1;
        else if (ovr_clr)                 ovr_n = 1'b0;

        case (state)
            IDLE: begin
                sout_n   = 1'b0;
                sframe_n = 1'b0;
                busy_n   = 1'b0;
                if (data_valid && first_found) begin
                    capture  = 1'b1;
                    state_n  = SHIFT;
                    ch_n     = first_idx;
                    bit_n    = '0;
                    div_n    = '0;
                    sout_n   = in_word[first_idx][WIDTH-1];
                    sframe_n = 1'b1;
                    strobe_n = 1'b1;
                    busy_n   = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_W'(DIV - 1)) begin
                    div_n = '0;
                    if (bit_cnt == BIT_W'(WORD - 1)) begin
                        if (next_found) begin
                            ch_n     = next_idx;
                            bit_n    = '0;
                            sout_n   = shadow_word[next_idx][WIDTH-1];
                            strobe_n = 1'b1;
                        end else begin
                            state_n  = GAP;
                            sout_n   = 1'b0;
                            sframe_n = 1'b0;
                        end
                    end else begin
                        bit_n    = bit_nx;
                        sout_n   = next_bit;
                        strobe_n = 1'b1;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_cnt == DIV_W'(DIV - 1)) begin
                    state_n = IDLE;
                    div_n   = '0;
                    busy_n  = 1'b0;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end
            default: begin
                state_n  = IDLE;
                sout_n   = 1'b0;
                sframe_n = 1'b0;
                busy_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            ch_ptr      <= '0;
            shadow_en   <= '0;
            sout        <= 1'b0;
            sframe      <= 1'b0;
            sbit_strobe <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            div_cnt     <= div_n;
            bit_cnt     <= bit_n;
            ch_ptr      <= ch_n;
            sout        <= sout_n;
            sframe      <= sframe_n;
            sbit_strobe <= strobe_n;
            busy        <= busy_n;
            overrun     <= ovr_n;
            if (capture) shadow_en <= ch_en;
        end
    end

    // Word shadow is pure data: only ever read after a capture has loaded it.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NUM_CH; k++) shadow_word[k] <= in_word[k];
        end
    end

endmodule

// File: tb/tb_cic3_row_readout.sv
// Bench for cic3_row_readout: three instances (DIV=4,1,2) share stimulus and are checked
// every cycle against a frame-level reference model, plus literal frame/bit expectations.
module tb_cic3_row_readout;
    localparam int NUM_CH = 12;
    localparam int WIDTH  = 25;
    localparam int ND     = 3;
    localparam int DIVS [ND] = '{4, 1, 2};
`ifdef CIC3_READOUT_PARITY_EN
    localparam int WORD_TB = 26;
    localparam int LIT_A_F [ND] = '{104, 26, 52};
    localparam int LIT_A_B [ND] = '{108, 27, 54};
    localparam int LIT_B_F [ND] = '{1248, 312, 624};
    localparam int LIT_B_B [ND] = '{1252, 313, 626};
    localparam int LIT_C_F [ND] = '{208, 52, 104};
    localparam int LIT_C_B [ND] = '{212, 53, 106};
`else
    localparam int WORD_TB = 25;
    localparam int LIT_A_F [ND] = '{100, 25, 50};
    localparam int LIT_A_B [ND] = '{104, 26, 52};
    localparam int LIT_B_F [ND] = '{1200, 300, 600};
    localparam int LIT_B_B [ND] = '{1204, 301, 602};
    localparam int LIT_C_F [ND] = '{200, 50, 100};
    localparam int LIT_C_B [ND] = '{204, 51, 102};
`endif
    localparam int MAXB = NUM_CH * WORD_TB;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    data_valid = 1'b0;
    logic                    ovr_clr = 1'b0;
    logic [NUM_CH*WIDTH-1:0] data_in = '0;
    logic [NUM_CH-1:0]       ch_en = '0;
    logic sout_w [ND];
    logic sframe_w [ND];
    logic sbit_w [ND];
    logic busy_w [ND];
    logic ovr_w [ND];

    int errors = 0;
    int checks = 0;
    int frame_cnt [ND];
    int busy_cnt [ND];
    bit s1 [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        cic3_row_readout #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV(DIVS[g])) u_dut (
            .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
            .ch_en(ch_en), .ovr_clr(ovr_clr), .sout(sout_w[g]), .sframe(sframe_w[g]),
            .sbit_strobe(sbit_w[g]), .busy(busy_w[g]), .overrun(ovr_w[g])
        );
    end

    // Reference: a frame is the ordered bit list of the enabled words, each bit DIV cycles long.
    logic [MAXB-1:0] m_bits [ND];
    int              m_cyc [ND];
    int              m_len [ND];
    logic            m_busy [ND];
    logic            m_ovr [ND];

    function automatic logic [MAXB-1:0] frame_bits(input logic [NUM_CH*WIDTH-1:0] din,
                                                   input logic [NUM_CH-1:0] en);
        logic [MAXB-1:0] r;
        int p;
        r = '0;
        p = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (en[k]) begin
                for (int b = WIDTH - 1; b >= 0; b--) begin
                    r[p] = din[k*WIDTH + b];
                    p++;
                end
                if (WORD_TB > WIDTH) begin
                    r[p] = ^din[k*WIDTH +: WIDTH];
                    p++;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < ND; d++) begin
                m_busy[d] <= 1'b0;
                m_cyc[d]  <= 0;
                m_ovr[d]  <= 1'b0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                if (m_busy[d]) begin
                    if (data_valid)   m_ovr[d] <= 1'b1;
                    else if (ovr_clr) m_ovr[d] <= 1'b0;
                    m_cyc[d] <= m_cyc[d] + 1;
                    if (m_cyc[d] + 1 >= m_len[d] * DIVS[d] + DIVS[d]) m_busy[d] <= 1'b0;
                end else begin
                    if (ovr_clr) m_ovr[d] <= 1'b0;
                    if (data_valid && ch_en != '0) begin
                        m_bits[d] <= frame_bits(data_in, ch_en);
                        m_len[d]  <= $countones(ch_en) * WORD_TB;
                        m_cyc[d]  <= 0;
                        m_busy[d] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        logic ef, eo, es;
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                ef = 1'b0;
                eo = 1'b0;
                es = 1'b0;
                if (m_busy[d] && m_cyc[d] < m_len[d] * DIVS[d]) begin
                    ef = 1'b1;
                    eo = m_bits[d][m_cyc[d] / DIVS[d]];
                    es = (m_cyc[d] % DIVS[d] == 0);
                end
                check("sout", d, 32'(sout_w[d]), 32'(eo));
                check("sframe", d, 32'(sframe_w[d]), 32'(ef));
                check("sbit_strobe", d, 32'(sbit_w[d]), 32'(es));
                check("busy", d, 32'(busy_w[d]), 32'(m_busy[d]));
                check("overrun", d, 32'(ovr_w[d]), 32'(m_ovr[d]));
                if (sframe_w[d]) frame_cnt[d]++;
                if (busy_w[d]) busy_cnt[d]++;
            end
            if (sbit_w[1]) s1.push_back(sout_w[1]);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
    endtask

    task automatic clear_meas();
        for (int d = 0; d < ND; d++) begin
            frame_cnt[d] = 0;
            busy_cnt[d]  = 0;
        end
        s1.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_w[0] || busy_w[1] || busy_w[2]) begin
            tick(1);
            n++;
            if (n > 3000) begin
                check("idle_timeout", n, 32'd1, 32'd0);
                break;
            end
        end
        tick(2);
    endtask

    task automatic set_word(input int k, input logic [WIDTH-1:0] w);
        data_in[k*WIDTH +: WIDTH] = w;
    endtask

    task automatic randomize_words();
        for (int k = 0; k < NUM_CH; k++) set_word(k, WIDTH'($urandom));
    endtask

    task automatic check_lengths(input string tag, input int lf [ND], input int lb [ND]);
        for (int d = 0; d < ND; d++) begin
            check({tag, "_frame_len"}, d, 32'(frame_cnt[d]), 32'(lf[d]));
            check({tag, "_busy_len"}, d, 32'(busy_cnt[d]), 32'(lb[d]));
        end
    endtask

    initial begin
        fork
            compare_loop();
        join_none
        tick(3);
        reset = 1'b0;
        tick(1);
        for (int d = 0; d < ND; d++) begin
            check("rst_busy", d, 32'(busy_w[d]), 32'd0);
            check("rst_sframe", d, 32'(sframe_w[d]), 32'd0);
            check("rst_overrun", d, 32'(ovr_w[d]), 32'd0);
        end

        // Single channel alternating pattern
        randomize_words();
        set_word(0, 25'h1555555);
        ch_en = 12'h001;
        clear_meas();
        pulse();
        wait_idle();
        check_lengths("A", LIT_A_F, LIT_A_B);
        check("A_bits", 0, 32'(s1.size()), 32'(WORD_TB));
        check("A_head", 0, 32'({s1[0], s1[1], s1[2], s1[3]}), 32'b1010);
        check("A_ovr", 0, 32'(ovr_w[0]), 32'd0);

`ifdef CIC3_READOUT_PARITY_EN
        set_word(0, 25'h0000007);
        clear_meas();
        pulse();
        wait_idle();
        check("P_tail", 0, 32'({s1[21], s1[22], s1[23], s1[24], s1[25]}), 32'b01111);
`endif

        // All channels, word k = k
        for (int k = 0; k < NUM_CH; k++) set_word(k, WIDTH'(k));
        ch_en = 12'hFFF;
        clear_meas();
        pulse();
        wait_idle();
        check_lengths("B", LIT_B_F, LIT_B_B);
        check("B_bits", 1, 32'(s1.size()), 32'(12 * WORD_TB));
        check("B_ch3", 1, 32'({s1[3*WORD_TB+22], s1[3*WORD_TB+23], s1[3*WORD_TB+24]}), 32'b011);
        check("B_ch5", 1, 32'({s1[5*WORD_TB+22], s1[5*WORD_TB+23], s1[5*WORD_TB+24]}), 32'b101);
        check("B_ch11", 1, 32'({s1[11*WORD_TB+21], s1[11*WORD_TB+22], s1[11*WORD_TB+23],
                                s1[11*WORD_TB+24]}), 32'b1011);

        // Sparse mask: channels 5 and 7 back to back
        randomize_words();
        ch_en = 12'h0A0;
        clear_meas();
        pulse();
        wait_idle();
        check_lengths("C", LIT_C_F, LIT_C_B);
        check("C_first", 1, 32'(s1[0]), 32'(data_in[5*WIDTH + WIDTH - 1]));
        check("C_second", 1, 32'(s1[WORD_TB]), 32'(data_in[7*WIDTH + WIDTH - 1]));

        // Overrun: second strobe mid-frame is dropped
        randomize_words();
        set_word(0, 25'h1555555);
        ch_en = 12'h001;
        clear_meas();
        pulse();
        tick(10);
        ch_en = 12'hFFF;
        randomize_words();
        pulse();
        ch_en = 12'h001;
        wait_idle();
        check_lengths("D", LIT_A_F, LIT_A_B);
        for (int d = 0; d < ND; d++) check("D_ovr_set", d, 32'(ovr_w[d]), 32'd1);
        pulse();
        tick(5);
        data_valid = 1'b1;
        ovr_clr = 1'b1;
        tick(1);
        data_valid = 1'b0;
        ovr_clr = 1'b0;
        for (int d = 0; d < ND; d++) check("D_set_wins", d, 32'(ovr_w[d]), 32'd1);
        wait_idle();
        ovr_clr = 1'b1;
        tick(1);
        ovr_clr = 1'b0;
        for (int d = 0; d < ND; d++) check("D_ovr_clr", d, 32'(ovr_w[d]), 32'd0);

        // Reset mid-frame (instance 0 at channel 2 bit 12), then a clean frame
        for (int k = 0; k < NUM_CH; k++) set_word(k, WIDTH'(k));
        ch_en = 12'hFFF;
        pulse();
        tick(249);
        reset = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check("E_rst_sout", d, 32'(sout_w[d]), 32'd0);
            check("E_rst_sframe", d, 32'(sframe_w[d]), 32'd0);
            check("E_rst_strobe", d, 32'(sbit_w[d]), 32'd0);
            check("E_rst_busy", d, 32'(busy_w[d]), 32'd0);
        end
        tick(1);
        reset = 1'b0;
        set_word(0, 25'h1000001);
        ch_en = 12'h001;
        clear_meas();
        pulse();
        wait_idle();
        check_lengths("E", LIT_A_F, LIT_A_B);
        check("E_head", 1, 32'({s1[0], s1[1], s1[24]}), 32'b101);

        // Empty mask is ignored
        ch_en = 12'h000;
        clear_meas();
        pulse();
        tick(4);
        for (int d = 0; d < ND; d++) begin
            check("F_busy", d, 32'(busy_cnt[d]), 32'd0);
            check("F_ovr", d, 32'(ovr_w[d]), 32'd0);
        end

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            data_valid = ($urandom_range(0, 39) == 0);
            ovr_clr    = ($urandom_range(0, 29) == 0);
            ch_en      = ($urandom_range(0, 9) == 0) ? 12'h000 : 12'($urandom);
            randomize_words();
            tick(1);
        end
        data_valid = 1'b0;
        ovr_clr = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
